mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one Booth multiplier instance (mult: start/Q/M in, product/fin out) between NREQ requesters.
//  Round-robin grant; latches the winner's operands, pulses mult start, waits for fin,
//  returns the product to the granted requester with a one-cycle done strobe. Adds fin-timeout detection.
// PARAMETERS
//  NREQ     2    number of requesters (2..4)
//  WIDTH    4    operand width; product is 2*WIDTH
//  TIMEOUT  64   max cycles in WAIT before error abort (>= multiplier latency + 2)
// PORTS
//  clk         in   1             system clock, all state on rising edge
//  rst_n       in   1             asynchronous active-low reset
//  req         in   NREQ          request i held high with operands stable until done[i]
//  opq         in   NREQ*WIDTH    Q operand of requester i at [i*WIDTH +: WIDTH]
//  opm         in   NREQ*WIDTH    M operand of requester i at [i*WIDTH +: WIDTH]
//  ack         out  NREQ          one-cycle pulse: request i granted, operands latched
//  done        out  NREQ          one-cycle pulse: result valid for requester i
//  result      out  2*WIDTH       product, valid while done!=0, held until next completion
//  err         out  1             one-cycle pulse with done: fin timeout, result forced 0
//  busy        out  1             1 in any state other than IDLE
//  mult_start  out  1             to mult start, one-cycle pulse per operation
//  mult_q      out  WIDTH         to mult Q, registered, stable from start through completion
//  mult_m      out  WIDTH         to mult M, registered, stable from start through completion
//  mult_prod   in   2*WIDTH       from mult product
//  mult_fin    in   1             from mult fin (level; may still be high from previous op)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ptr=0, ack=0, done=0, err=0, busy=0, mult_start=0,
//   mult_q=0, mult_m=0, result=0, cnt=0, armed=0. In-flight op discarded, no done issued.
//  FSM: IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: if req!=0, pick first set bit scanning ptr, ptr+1, ... mod NREQ -> gid.
//   Same edge: ack[gid]=1, mult_start=1, mult_q/mult_m <= operands of gid, cnt=0, armed=0, ->WAIT.
//   req==0: stay, all strobes 0.
//  WAIT: ack=0, mult_start=0 (start high exactly one cycle). cnt increments each cycle.
//   armed<=1 on first cycle mult_fin sampled 0; stale fin=1 before arming ignored.
//   armed && mult_fin==1 -> latch result<=mult_prod, ->DONE.
//   cnt==TIMEOUT-1 without completion -> result<=0, err flag set, ->DONE.
//  DONE (one cycle): done[gid]=1, err=1 iff timeout, ptr<=(gid+1) mod NREQ, ->IDLE.
//  Earliest next ack is the cycle after DONE; busy low in that IDLE cycle.
//  Arithmetic: product passed through unmodified (signed Booth result, 2*WIDTH bits); no widening.
//  req[i] dropped before grant: not served. Dropped after ack: op completes, done[i] still pulses.
//  req[i] changing operands after ack: no effect (operands latched).
//  Simultaneous requests: only one ack per cycle; others wait, order strictly round-robin.
//  Single persistent requester re-granted after each DONE (ptr wrap does not starve it).
//  Strobes (ack, done, err, mult_start) are registered, never combinational from inputs.
// TESTING
//  1 Reset: assert rst_n=0 mid-sim -> all outputs 0 same time step; mult_start stays 0 after release.
//  2 Single op: req=01, Q0=4'b0011, M0=4'b0010 -> ack=01 + mult_start 1 cycle, later done=01, result=8'd6.
//  3 Signed: Q0=4'b1101(-3), M0=4'b0010 -> result=8'hFA, err=0.
//  4 Contention: req=11 held, ptr=0 -> grants 0,1,0,1; each done follows its own ack; no double ack.
//  5 Stale fin: mult model holds fin=1 for 2 cycles after start -> no early done; done only after
//    fin goes 0 then 1; result equals new product.
//  6 Timeout: mult model holds fin=0 -> after TIMEOUT cycles in WAIT done[gid]=1, err=1, result=0;
//    then reset during WAIT of a new op -> no done, IDLE, ptr=0.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one Booth multiplier among NREQ requesters
module mult_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   opq,
  input  logic [NREQ*WIDTH-1:0]   opm,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         done,
  output logic [2*WIDTH-1:0]      result,
  output logic                    err,
  output logic                    busy,
  output logic                    mult_start,
  output logic [WIDTH-1:0]        mult_q,
  output logic [WIDTH-1:0]        mult_m,
  input  logic [2*WIDTH-1:0]      mult_prod,
  input  logic                    mult_fin
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gid;
  logic [CW-1:0]   cnt;
  logic            armed;
  logic [PW-1:0]   pick_id;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // Winner is the set request at the smallest rotational distance from ptr.
  always_comb begin
    int best;
    int off;
    best    = NREQ;
    off     = 0;
    pick_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - int'(ptr)) % NREQ;
      if (req[i] && off < best) begin
        best    = off;
        pick_id = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      gid        <= '0;
      cnt        <= '0;
      armed      <= 1'b0;
      ack        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      mult_q     <= '0;
      mult_m     <= '0;
      result     <= '0;
    end else begin
      ack        <= '0;
      done       <= '0;
      err        <= 1'b0;
      mult_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            gid        <= pick_id;
            ack        <= onehot(pick_id);
            mult_start <= 1'b1;
            mult_q     <= opq[int'(pick_id)*WIDTH +: WIDTH];
            mult_m     <= opm[int'(pick_id)*WIDTH +: WIDTH];
            cnt        <= '0;
            armed      <= 1'b0;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A fin left high by the previous op only counts once it has been seen low.
          if (armed && mult_fin) begin
            result <= mult_prod;
            done   <= onehot(gid);
            state  <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            result <= '0;
            err    <= 1'b1;
            done   <= onehot(gid);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (!mult_fin) armed <= 1'b1;
          end
        end
        S_DONE: begin
          ptr   <= (gid == PW'(NREQ - 1)) ? '0 : gid + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;

  localparam int NREQ = 2;
  localparam int WIDTH = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] opq, opm;
  logic [NREQ-1:0]       ack, done;
  logic [2*WIDTH-1:0]    result;
  logic                  err, busy, mult_start;
  logic [WIDTH-1:0]      mult_q, mult_m;
  logic [2*WIDTH-1:0]    mult_prod;
  logic                  mult_fin;

  int checks = 0;
  int errors = 0;
  int mode;
  int k;
  logic run;
  int n;
  bit ok;
  logic [NREQ-1:0] seen;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opq(opq), .opm(opm),
    .ack(ack), .done(done), .result(result), .err(err), .busy(busy),
    .mult_start(mult_start), .mult_q(mult_q), .mult_m(mult_m),
    .mult_prod(mult_prod), .mult_fin(mult_fin)
  );

  // mode 0: normal, 1: fin held high 2 cycles after start, 2: fin never rises
  initial begin
    mult_fin = 1'b0; mult_prod = '0; k = 0; run = 1'b0;
  end
  always @(posedge clk) begin
    if (mult_start) begin
      k   <= 1;
      run <= 1'b1;
      if (mode != 1) mult_fin <= 1'b0;
    end else if (run) begin
      k <= k + 1;
      if (mode == 0 && k == LAT) begin
        mult_fin  <= 1'b1;
        mult_prod <= {{WIDTH{mult_q[WIDTH-1]}}, mult_q} * {{WIDTH{mult_m[WIDTH-1]}}, mult_m};
        run       <= 1'b0;
      end else if (mode == 1 && k == 2) begin
        mult_fin <= 1'b0;
      end else if (mode == 1 && k == 5) begin
        mult_fin  <= 1'b1;
        mult_prod <= {{WIDTH{mult_q[WIDTH-1]}}, mult_q} * {{WIDTH{mult_m[WIDTH-1]}}, mult_m};
        run       <= 1'b0;
      end else if (mode == 2) begin
        mult_fin <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input bit want_done, output int cnt, output bit found);
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (want_done ? (done != '0) : (ack != '0)) found = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; opq = '0; opm = '0; mode = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ack, done, result, err, busy, mult_start, mult_q, mult_m}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_quiet", {mult_start, busy, ack, done}, 0);

    // single unsigned op on requester 0
    opq[3:0] = 4'b0011; opm[3:0] = 4'b0010; req = 2'b01;
    wait_sig(1'b0, n, ok);
    chk("s2_ack_seen", ok, 1);
    chk("s2_ack", ack, 2'b01);
    chk("s2_start", mult_start, 1);
    chk("s2_busy", busy, 1);
    chk("s2_q_m", {mult_q, mult_m}, 8'h32);
    @(negedge clk);
    chk("s2_strobes_one_cycle", {ack, mult_start}, 0);
    wait_sig(1'b1, n, ok);
    chk("s2_done_seen", ok, 1);
    chk("s2_done", done, 2'b01);
    chk("s2_result", result, 8'd6);
    chk("s2_err", err, 0);
    req = '0;
    @(negedge clk);
    chk("s2_idle_after", {busy, done, err}, 0);
    chk("s2_result_held", result, 8'd6);

    // signed op on requester 1
    opq[7:4] = 4'b1101; opm[7:4] = 4'b0010; req = 2'b10;
    wait_sig(1'b0, n, ok);
    chk("s3_ack", ack, 2'b10);
    wait_sig(1'b1, n, ok);
    chk("s3_done", done, 2'b10);
    chk("s3_result", result, 8'hFA);
    chk("s3_err", err, 0);
    req = '0;
    @(negedge clk);

    // contention from ptr=0: grants 0,1,0,1
    opq = 8'h52; opm = 8'hF3; req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_sig(1'b0, n, ok);
      chk("s4_ack", ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      wait_sig(1'b1, n, ok);
      chk("s4_done", done, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("s4_result", result, (i % 2 == 0) ? 8'h06 : 8'hFB);
      if (i == 3) req = '0;
      @(negedge clk);
      chk("s4_idle_gap", {busy, ack}, 0);
    end

    // stale fin held high after start
    mode = 1; opq[7:4] = 4'd7; opm[7:4] = 4'd7; req = 2'b10;
    wait_sig(1'b0, n, ok);
    chk("s5_ack", ack, 2'b10);
    wait_sig(1'b1, n, ok);
    chk("s5_not_early", (n >= 5), 1);
    chk("s5_done", done, 2'b10);
    chk("s5_result", result, 8'h31);
    chk("s5_err", err, 0);
    req = '0;
    @(negedge clk);

    // fin never arrives: timeout after TIMEOUT cycles in WAIT
    mode = 2; opq[3:0] = 4'd3; opm[3:0] = 4'd3; req = 2'b01;
    wait_sig(1'b0, n, ok);
    chk("s6_ack", ack, 2'b01);
    wait_sig(1'b1, n, ok);
    chk("s6_timeout_cycles", n, TIMEOUT);
    chk("s6_done", done, 2'b01);
    chk("s6_err", err, 1);
    chk("s6_result_zero", result, 0);
    req = '0;
    @(negedge clk);
    chk("s6_err_pulse", {err, done, busy}, 0);

    // reset while an op for requester 1 is in WAIT
    req = 2'b10;
    wait_sig(1'b0, n, ok);
    chk("s7_ack", ack, 2'b10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req = '0;
    #1;
    chk("s7_reset_outputs", {ack, done, result, err, busy, mult_start, mult_q, mult_m}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | done | {busy, mult_start};
    end
    chk("s7_no_done_after_reset", seen, 0);
    mode = 0; opq[3:0] = 4'd5; opm[3:0] = 4'd3; req = 2'b11;
    wait_sig(1'b0, n, ok);
    chk("s7_ptr_reset_ack", ack, 2'b01);
    wait_sig(1'b1, n, ok);
    chk("s7_done", done, 2'b01);
    chk("s7_result", result, 8'h0F);
    req = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
